rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: ALU/execute (req 0) and load/store unit (req 1).
- Uses round-robin arbitration with a registered output stage that drives the register file's write_en/write_addr/write_data directly.
- Keeps a per-register pending-write scoreboard, set at issue and cleared at commit, so decode can stall on read-after-write hazards.
- Sits between the execute/memory stages and the register file in the pipelined core.

Parameters:
- XLEN, 32, data width of writeback values and of rf_wdata
- NREG, 32, number of architectural registers; address width is fixed at 5

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- lsu_valid  in  1  LSU writeback request
- lsu_ready  out  1  LSU request accepted this cycle
- lsu_rd  in  5  LSU destination register
- lsu_data  in  XLEN  load result
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  XLEN  register-file write data
- issue_valid  in  1  decode issues an instruction that writes issue_rd
- issue_rd  in  5  destination of the issuing instruction
- issue_ready  out  1  issue_rd has no pending write
- rs1_addr  in  5  decode source 1
- rs2_addr  in  5  decode source 2
- rs1_pending  out  1  rs1 has a write in flight
- rs2_pending  out  1  rs2 has a write in flight

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - pending[NREG-1:0]=0.
  - last_grant=1 (LSU), so the ALU wins the first contention.
  - rst overrides every other input in that cycle, including an in-flight grant; nothing commits.
- Arbitration (combinational grant, registered result):
  - Only one valid request: grant it.
  - Both valid: grant the requester that is not last_grant, then set last_grant to the winner.
  - A single-request grant also updates last_grant.
  - ready is high only for the granted requester, only when its valid=1, and never during rst.
  - Handshake = valid & ready. A requester holds valid, rd and data stable until ready.
  - The loser waits at most one cycle.
- Output stage:
  - On a handshake at cycle N, rf_we/rf_waddr/rf_wdata show the request at cycle N+1.
  - The register file writes at the edge ending cycle N+1.
  - rf_we=0 in any cycle after one with no handshake.
- x0 rule:
  - A request with rd=0 is accepted (ready=1, counts as a grant) but rf_we stays 0.
  - pending[0] is never set. rs*_pending=0 when rs*_addr=0. issue_ready=1 when issue_rd=0.
- Scoreboard:
  - issue_ready = !pending[issue_rd].
  - On issue_valid & issue_ready with issue_rd≠0: set pending[issue_rd] at posedge.
  - issue_valid with issue_ready=0 is ignored; decode must stall.
  - Clear pending[rf_waddr] at the posedge where rf_we=1, i.e. the same edge the register file writes.
  - From cycle N+2 onward: pending=0 and the register-file read returns the new value.
  - Set and clear of the same register at the same edge: set wins.
  - rs1_pending = pending[rs1_addr]; rs2_pending = pending[rs2_addr]. Both are combinational.
- No internal queueing:
  - Throughput is one write per cycle.
  - Both requesters valid continuously → strict alternation.
- The block does not check the other side's consistency. It does not detect a writeback whose rd was never issued; that write commits and clears nothing extra.

Decomposition:
- Shared package (core_pkg):
  - XLEN, NREG, REG_ADDR_W=5.
  - Requester index constants REQ_ALU=0, REQ_LSU=1.
- One sub-module: rf_scoreboard, holding the pending vector, set/clear logic, issue_ready and the rs*_pending lookups.
- The arbiter and output register stay in rf_wb_arbiter.

Test Plan:
- Reset: hold rst 2 cycles with alu_valid=1 → alu_ready=0, rf_we=0 throughout, all pending=0, issue_ready=1.
- Single write:
  - Stimulus: issue rd=5 at cycle 0, then alu_valid, rd=5, data=0xDEADBEEF at cycle 3.
  - Cycles 1–3: rs1_addr=5 gives rs1_pending=1, and issue_ready=0 for rd=5.
  - Cycle 4: rf_we=1, waddr=5, wdata=0xDEADBEEF.
  - Cycle 5: rs1_pending=0.
- Contention:
  - Stimulus: ALU (rd=3, 0x11) and LSU (rd=4, 0x22) both valid from cycle 0, held until accepted.
  - Cycle 0: alu_ready=1. Cycle 1: rf_we writes 3/0x11 and lsu_ready=1. Cycle 2: rf_we writes 4/0x22.
  - Next contention: LSU wins.
- Continuous streams:
  - Stimulus: both requesters valid for 8 cycles.
  - Grants alternate ALU, LSU, ALU, …; rf_we=1 on cycles 1–8, 4 writes each.
- x0 and reissue:
  - LSU writes rd=0 → lsu_ready=1, rf_we stays 0.
  - Issue rd=7 in the same cycle rf_we commits rd=7 → pending[7]=1 afterward (set wins).
- Mid-operation reset:
  - Stimulus: handshake at cycle N, rst=1 at cycle N+1.
  - Required: rf_we=0 at N+2 and pending cleared.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core constants: data width, register count,
// register address width and writeback requester ids.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NADDR      = 1 << REG_ADDR_W;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  function automatic logic [NADDR-1:0] addr_onehot(
    input reg_addr_t a
  );
    addr_onehot = NADDR'(1) << a;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: set on issue, cleared on commit.
// Ports: issue_valid/issue_rd/issue_ready, rs1/rs2 lookups, wb_we/wb_addr commit.
module rf_scoreboard
  import core_pkg::*;
#(
  parameter int NREG = core_pkg::NREG
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      issue_valid,
  input  reg_addr_t issue_rd,
  output logic      issue_ready,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  output logic      rs1_pending,
  output logic      rs2_pending,
  input  logic      wb_we,
  input  reg_addr_t wb_addr
);

  logic [NREG-1:0]  pending;
  logic [NREG-1:0]  pending_nxt;
  logic [NADDR-1:0] pend_ext;
  logic [NADDR-1:0] set_mask;
  logic [NADDR-1:0] clr_mask;
  logic             issue_go;

  // Widen to the full address space so any 5-bit
  // address is a legal index; unused entries read 0.
  always_comb begin
    pend_ext = '0;
    pend_ext[NREG-1:0] = pending;
  end

  assign issue_ready = ~pend_ext[issue_rd];
  assign rs1_pending = pend_ext[rs1_addr];
  assign rs2_pending = pend_ext[rs2_addr];

  assign issue_go =
    issue_valid & issue_ready & (issue_rd != '0);

  assign set_mask =
    addr_onehot(issue_rd) & {NADDR{issue_go}};
  assign clr_mask =
    addr_onehot(wb_addr) & {NADDR{wb_we}};

  // Clear first, then set: a reissue on the commit
  // edge keeps the register pending.
  always_comb begin
    pending_nxt = (pending & ~clr_mask[NREG-1:0])
                | set_mask[NREG-1:0];
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter of ALU/LSU writebacks onto the single RF write port.
// Ports: alu_*/lsu_* requests, rf_we/rf_waddr/rf_wdata, issue_*/rs*_* scoreboard.
module rf_wb_arbiter
  import core_pkg::*;
#(
  parameter int XLEN = core_pkg::XLEN,
  parameter int NREG = core_pkg::NREG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  reg_addr_t       alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  reg_addr_t       lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            rf_we,
  output reg_addr_t       rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  input  logic            issue_valid,
  input  reg_addr_t       issue_rd,
  output logic            issue_ready,
  input  reg_addr_t       rs1_addr,
  input  reg_addr_t       rs2_addr,
  output logic            rs1_pending,
  output logic            rs2_pending
);

  logic            last_grant;
  logic            gnt_alu;
  logic            gnt_lsu;
  logic            hs;
  reg_addr_t       win_rd;
  logic [XLEN-1:0] win_data;

  always_comb begin
    gnt_alu = 1'b0;
    gnt_lsu = 1'b0;
    unique case (1'b1)
      (alu_valid & lsu_valid): begin
        if (last_grant == REQ_LSU) gnt_alu = 1'b1;
        else                       gnt_lsu = 1'b1;
      end
      (alu_valid & ~lsu_valid): gnt_alu = 1'b1;
      (~alu_valid & lsu_valid): gnt_lsu = 1'b1;
      default: ;
    endcase
  end

  assign alu_ready = gnt_alu & ~rst;
  assign lsu_ready = gnt_lsu & ~rst;
  assign hs        = alu_ready | lsu_ready;

  assign win_rd   = lsu_ready ? lsu_rd   : alu_rd;
  assign win_data = lsu_ready ? lsu_data : alu_data;

  // x0 writes are granted but never reach the RF.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      last_grant <= REQ_LSU;
    end else begin
      rf_we <= hs & (win_rd != '0);
      if (hs) begin
        rf_waddr   <= win_rd;
        rf_wdata   <= win_data;
        last_grant <= lsu_ready ? REQ_LSU : REQ_ALU;
      end
    end
  end

  rf_scoreboard #(
    .NREG (NREG)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_pending (rs1_pending),
    .rs2_pending (rs2_pending),
    .wb_we       (rf_we),
    .wb_addr     (rf_waddr)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_rf_wb_arbiter;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        issue_ready;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic        rs1_pending;
  logic        rs2_pending;

  int tests = 0;
  int fails = 0;

  // behavioural model
  bit          m_last;
  bit          m_pend [32];
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(issue_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_pending(rs1_pending), .rs2_pending(rs2_pending)
  );

  function automatic int model_winner();
    if (alu_valid && lsu_valid) return m_last ? 0 : 1;
    if (alu_valid) return 0;
    if (lsu_valid) return 1;
    return -1;
  endfunction

  // Advance one clock edge and update the model from
  // the inputs applied during the cycle that just ended.
  task automatic tick();
    int g;
    bit ir;
    @(posedge clk);
    if (rst) begin
      m_last = 1'b1;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_we = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
    end else begin
      g = model_winner();
      ir = (issue_rd == 0) || !m_pend[issue_rd];
      if (m_we) m_pend[m_waddr] = 1'b0;
      if (issue_valid && ir && issue_rd != 0)
        m_pend[issue_rd] = 1'b1;
      m_we = 1'b0;
      if (g == 0) begin
        m_last = 1'b0;
        m_we = (alu_rd != 0);
        m_waddr = alu_rd;
        m_wdata = alu_data;
      end else if (g == 1) begin
        m_last = 1'b1;
        m_we = (lsu_rd != 0);
        m_waddr = lsu_rd;
        m_wdata = lsu_data;
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    alu_valid = 0; lsu_valid = 0; issue_valid = 0;
    alu_rd = 0; lsu_rd = 0; issue_rd = 0;
    rs1_addr = 0; rs2_addr = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h55;
    issue_rd = 5'd3;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tests++;
      if (alu_ready !== 1'b0) begin
        fails++;
        $display("FAIL reset_alu_ready c%0d got %b exp 0", c, alu_ready);
      end
      tests++;
      if (rf_we !== 1'b0) begin
        fails++;
        $display("FAIL reset_rf_we c%0d got %b exp 0", c, rf_we);
      end
      tests++;
      if (issue_ready !== 1'b1) begin
        fails++;
        $display("FAIL reset_issue_ready c%0d got %b exp 1", c, issue_ready);
      end
      tick();
    end
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      fails++;
      $display("FAIL reset_wbus got %0d/%h exp 0/0", rf_waddr, rf_wdata);
    end
    tick();
    for (int i = 0; i < 16; i++) begin
      rs1_addr = 5'(2 * i);
      rs2_addr = 5'(2 * i + 1);
      issue_rd = 5'(2 * i + 1);
      @(negedge clk);
      tests++;
      if (rs1_pending !== 1'b0 || rs2_pending !== 1'b0
          || issue_ready !== 1'b1) begin
        fails++;
        $display("FAIL reset_pending r%0d got %b%b%b exp 001",
                 2 * i, rs1_pending, rs2_pending, issue_ready);
      end
      tick();
    end
  endtask

  task automatic test_single_write();
    apply_reset();
    issue_valid = 1; issue_rd = 5'd5; rs1_addr = 5'd5;
    @(negedge clk);
    tests++;
    if (issue_ready !== 1'b1) begin
      fails++;
      $display("FAIL single_issue got %b exp 1", issue_ready);
    end
    tick();
    issue_valid = 0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin
        alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      end
      @(negedge clk);
      tests++;
      if (rs1_pending !== 1'b1 || issue_ready !== 1'b0) begin
        fails++;
        $display("FAIL single_pending c%0d got %b/%b exp 1/0",
                 c, rs1_pending, issue_ready);
      end
      tick();
    end
    alu_valid = 0;
    @(negedge clk);
    tests++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5
        || rf_wdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL single_write got %b/%0d/%h exp 1/5/deadbeef",
               rf_we, rf_waddr, rf_wdata);
    end
    tick();
    @(negedge clk);
    tests++;
    if (rs1_pending !== 1'b0 || rf_we !== 1'b0) begin
      fails++;
      $display("FAIL single_clear got %b/%b exp 0/0", rs1_pending, rf_we);
    end
    tick();
  endtask

  task automatic test_contention();
    apply_reset();
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h11;
    lsu_valid = 1; lsu_rd = 5'd4; lsu_data = 32'h22;
    @(negedge clk);
    tests++;
    if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      fails++;
      $display("FAIL cont_c0 got %b%b exp 10", alu_ready, lsu_ready);
    end
    tick();
    // ALU immediately requests again: LSU now wins
    alu_rd = 5'd6; alu_data = 32'h66;
    @(negedge clk);
    tests++;
    if (alu_ready !== 1'b0 || lsu_ready !== 1'b1) begin
      fails++;
      $display("FAIL cont_c1 got %b%b exp 01", alu_ready, lsu_ready);
    end
    tests++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h11) begin
      fails++;
      $display("FAIL cont_w1 got %b/%0d/%h exp 1/3/11",
               rf_we, rf_waddr, rf_wdata);
    end
    tick();
    lsu_valid = 0;
    @(negedge clk);
    tests++;
    if (alu_ready !== 1'b1) begin
      fails++;
      $display("FAIL cont_c2 got %b exp 1", alu_ready);
    end
    tests++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h22) begin
      fails++;
      $display("FAIL cont_w2 got %b/%0d/%h exp 1/4/22",
               rf_we, rf_waddr, rf_wdata);
    end
    tick();
    alu_valid = 0;
    @(negedge clk);
    tests++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'h66) begin
      fails++;
      $display("FAIL cont_w3 got %b/%0d/%h exp 1/6/66",
               rf_we, rf_waddr, rf_wdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int aw = 0;
    int lw = 0;
    bit a_acc;
    bit l_acc;
    apply_reset();
    alu_valid = 1; alu_rd = 5'd10; alu_data = 32'hA0;
    lsu_valid = 1; lsu_rd = 5'd20; lsu_data = 32'hB0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests++;
      if (alu_ready !== (i % 2 == 0) || lsu_ready !== (i % 2 == 1)) begin
        fails++;
        $display("FAIL b2b_grant c%0d got %b%b", i, alu_ready, lsu_ready);
      end
      if (i > 0) begin
        tests++;
        if (rf_we !== 1'b1) begin
          fails++;
          $display("FAIL b2b_we c%0d got %b exp 1", i, rf_we);
        end
        if (rf_waddr >= 5'd20) lw++;
        else aw++;
      end
      a_acc = alu_ready;
      l_acc = lsu_ready;
      tick();
      if (a_acc) begin alu_rd++; alu_data++; end
      if (l_acc) begin lsu_rd++; lsu_data++; end
    end
    alu_valid = 0;
    lsu_valid = 0;
    @(negedge clk);
    tests++;
    if (rf_we !== 1'b1) begin
      fails++;
      $display("FAIL b2b_we c8 got %b exp 1", rf_we);
    end
    if (rf_waddr >= 5'd20) lw++;
    else aw++;
    tick();
    tests++;
    if (aw != 4 || lw != 4) begin
      fails++;
      $display("FAIL b2b_counts got alu=%0d lsu=%0d exp 4/4", aw, lw);
    end
  endtask

  task automatic test_x0_reissue();
    apply_reset();
    lsu_valid = 1; lsu_rd = 5'd0; lsu_data = 32'hFFFF;
    @(negedge clk);
    tests++;
    if (lsu_ready !== 1'b1) begin
      fails++;
      $display("FAIL x0_ready got %b exp 1", lsu_ready);
    end
    tick();
    lsu_valid = 0;
    alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h77;
    @(negedge clk);
    tests++;
    if (rf_we !== 1'b0) begin
      fails++;
      $display("FAIL x0_we got %b exp 0", rf_we);
    end
    tick();
    alu_valid = 0;
    issue_valid = 1; issue_rd = 5'd7;
    @(negedge clk);
    tests++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || issue_ready !== 1'b1) begin
      fails++;
      $display("FAIL reissue_commit got %b/%0d/%b exp 1/7/1",
               rf_we, rf_waddr, issue_ready);
    end
    tick();
    issue_valid = 0;
    rs1_addr = 5'd7;
    rs2_addr = 5'd0;
    @(negedge clk);
    tests++;
    if (rs1_pending !== 1'b1 || issue_ready !== 1'b0) begin
      fails++;
      $display("FAIL reissue_set got %b/%b exp 1/0", rs1_pending, issue_ready);
    end
    issue_rd = 5'd0;
    #1;
    tests++;
    if (rs2_pending !== 1'b0 || issue_ready !== 1'b1) begin
      fails++;
      $display("FAIL x0_lookup got %b/%b exp 0/1", rs2_pending, issue_ready);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    apply_reset();
    issue_valid = 1; issue_rd = 5'd9;
    @(negedge clk);
    tick();
    issue_valid = 0;
    alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h99;
    @(negedge clk);
    tests++;
    if (alu_ready !== 1'b1) begin
      fails++;
      $display("FAIL midrst_hs got %b exp 1", alu_ready);
    end
    tick();
    alu_valid = 0;
    rst = 1;
    @(negedge clk);
    tests++;
    if (rf_we !== 1'b1) begin
      fails++;
      $display("FAIL midrst_n1 got %b exp 1", rf_we);
    end
    tick();
    rst = 0;
    rs1_addr = 5'd9;
    @(negedge clk);
    tests++;
    if (rf_we !== 1'b0 || rs1_pending !== 1'b0 || issue_ready !== 1'b1) begin
      fails++;
      $display("FAIL midrst_n2 got %b/%b/%b exp 0/0/1",
               rf_we, rs1_pending, issue_ready);
    end
    tick();
  endtask

  task automatic test_random();
    bit a_acc = 0;
    bit l_acc = 0;
    int g;
    bit e_ir;
    bit e_r1;
    bit e_r2;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      if (!alu_valid || a_acc) begin
        alu_valid = ($urandom % 3) != 0;
        alu_rd = 5'($urandom_range(0, 7));
        alu_data = $urandom;
      end
      if (!lsu_valid || l_acc) begin
        lsu_valid = ($urandom % 3) != 0;
        lsu_rd = 5'($urandom_range(0, 7));
        lsu_data = $urandom;
      end
      issue_valid = $urandom % 2;
      issue_rd = 5'($urandom_range(0, 7));
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 7));
      @(negedge clk);
      g = model_winner();
      e_ir = (issue_rd == 0) || !m_pend[issue_rd];
      e_r1 = (rs1_addr != 0) && m_pend[rs1_addr];
      e_r2 = (rs2_addr != 0) && m_pend[rs2_addr];
      tests++;
      if (alu_ready !== (g == 0) || lsu_ready !== (g == 1)) begin
        fails++;
        $display("FAIL rnd_grant c%0d got %b%b exp winner %0d",
                 c, alu_ready, lsu_ready, g);
      end
      tests++;
      if (rf_we !== m_we
          || (m_we && (rf_waddr !== m_waddr || rf_wdata !== m_wdata))) begin
        fails++;
        $display("FAIL rnd_wb c%0d got %b/%0d/%h exp %b/%0d/%h",
                 c, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
      end
      tests++;
      if (issue_ready !== e_ir || rs1_pending !== e_r1
          || rs2_pending !== e_r2) begin
        fails++;
        $display("FAIL rnd_sb c%0d got %b%b%b exp %b%b%b", c,
                 issue_ready, rs1_pending, rs2_pending, e_ir, e_r1, e_r2);
      end
      a_acc = alu_ready;
      l_acc = lsu_ready;
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_back_to_back();
    test_x0_reissue();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
